// File: rtl/display_pkg.sv
// display_pkg: segment type, dark pattern and hex-to-segment decode shared by the display blocks.
package display_pkg;
   typedef logic [6:0] seg_t;
   localparam seg_t SEG_OFF = 7'b0000000;
   function automatic seg_t hex_to_seg(input logic [3:0] nib);
      case (nib)
         4'h0: return 7'b1111110;
         4'h1: return 7'b0110000;
         4'h2: return 7'b1101101;
         4'h3: return 7'b1111001;
         4'h4: return 7'b0110011;
         4'h5: return 7'b1011011;
         4'h6: return 7'b1011111;
         4'h7: return 7'b1110000;
         4'h8: return 7'b1111111;
         4'h9: return 7'b1111011;
         4'hA: return 7'b1110111;
         4'hB: return 7'b0011111;
         4'hC: return 7'b1001110;
         4'hD: return 7'b0111101;
         4'hE: return 7'b1001111;
         default: return 7'b1000111;
      endcase
   endfunction
endpackage

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder: combinational nibble to segment pattern (bit6=a .. bit0=g, 1 = lit).
module seg7_hex_decoder
   import display_pkg::*;
(
   input  logic [3:0] i_nibble,
   output seg_t       o_seg
);
   assign o_seg = hex_to_seg(i_nibble);
endmodule

// File: rtl/display_mux_nd.sv
// display_mux_nd: N-digit multiplexed 7-segment driver with frame-aligned double-buffered loads.
// Define DISPLAY_LZB_EN to enable leading-zero blanking.
module display_mux_nd
   import display_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int CLK_DIV    = 50000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic                    load_valid,
   output logic                    load_ready,
   output logic [NUM_DIGITS-1:0]   anodo,
   output seg_t                    catodo,
   output logic                    dp_out,
   output logic                    frame_tick
);
   localparam int CW = $clog2(CLK_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   logic [CW-1:0]           r_cnt;
   logic [IW-1:0]           r_idx;
   logic                    r_wrap_d, r_frame, r_pend_full;
   logic [4*NUM_DIGITS-1:0] r_pend_data, r_act_data;
   logic [NUM_DIGITS-1:0]   r_pend_dp, r_pend_blank, r_act_dp, r_act_blank, r_an;
   seg_t                    r_cat;
   logic                    r_dp;
   logic                    w_slot, w_wrap, w_dp, w_dark;
   logic [3:0]              w_nib;
   seg_t                    w_seg;
   assign w_slot = r_cnt == CW'(CLK_DIV - 1);
   assign w_wrap = w_slot && r_idx == IW'(NUM_DIGITS - 1);
   assign w_nib  = r_act_data[{r_idx, 2'b00} +: 4];
   assign w_dp   = r_act_dp[r_idx];
`ifdef DISPLAY_LZB_EN
   // Dark when this digit and every digit above it are zero; digit 0 and lit dp stay visible.
   assign w_dark = r_act_blank[r_idx] ||
                   ((r_act_data >> {r_idx, 2'b00}) == '0 && r_idx != '0 && !w_dp);
`else
   assign w_dark = r_act_blank[r_idx];
`endif
   seg7_hex_decoder u_dec (.i_nibble(w_nib), .o_seg(w_seg));
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt        <= '0;
         r_idx        <= '0;
         r_wrap_d     <= 1'b0;
         r_frame      <= 1'b0;
         r_pend_full  <= 1'b0;
         r_pend_data  <= '0;
         r_pend_dp    <= '0;
         r_pend_blank <= '0;
         r_act_data   <= '0;
         r_act_dp     <= '0;
         r_act_blank  <= '0;
         r_an         <= '1;
         r_cat        <= SEG_OFF;
         r_dp         <= 1'b0;
      end else begin
         r_cnt    <= w_slot ? '0 : r_cnt + 1'b1;
         r_idx    <= w_wrap ? '0 : w_slot ? r_idx + 1'b1 : r_idx;
         r_wrap_d <= w_wrap;
         r_frame  <= r_wrap_d;
         // Commit happens at the wrap edge so the first digit-0 output already uses new data.
         if (w_wrap && r_pend_full) begin
            r_act_data  <= r_pend_data;
            r_act_dp    <= r_pend_dp;
            r_act_blank <= r_pend_blank;
            r_pend_full <= 1'b0;
         end else if (load_valid && !r_pend_full) begin
            r_pend_data  <= data_in;
            r_pend_dp    <= dp_in;
            r_pend_blank <= blank_in;
            r_pend_full  <= 1'b1;
         end
         r_an  <= w_dark ? '1 : ~(NUM_DIGITS'(1) << r_idx);
         r_cat <= w_dark ? SEG_OFF : w_seg;
         r_dp  <= !w_dark && w_dp;
      end
   end
   assign load_ready = !r_pend_full;
   assign anodo      = r_an;
   assign catodo     = r_cat;
   assign dp_out     = r_dp;
   assign frame_tick = r_frame;
endmodule

// File: tb/tb_display_mux_nd.sv
// tb_display_mux_nd: randomized checks of display_mux_nd (4 digits, 4 clk per slot) against an edge-count model.
module tb_display_mux_nd;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] data_in = '0;
   logic [3:0]  dp_in = '0, blank_in = '0;
   logic        load_valid = 1'b0;
   logic        load_ready, dp_out, frame_tick;
   logic [3:0]  anodo;
   logic [6:0]  catodo;
   int          n_chk = 0, n_pass = 0;
   display_mux_nd #(.NUM_DIGITS(4), .CLK_DIV(4)) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
      .load_valid(load_valid), .load_ready(load_ready), .anodo(anodo), .catodo(catodo),
      .dp_out(dp_out), .frame_tick(frame_tick)
   );
   always #5 clk = ~clk;
   logic [6:0] seg_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
   // Model: m_e counts rising edges since release; every 16th edge is a frame boundary.
   int          m_e = 0;
   logic        m_pend_full = 1'b0;
   logic [15:0] m_pend_data = '0, m_act_data = '0, m_disp_data = '0;
   logic [3:0]  m_pend_dp = '0, m_pend_blank = '0, m_act_dp = '0, m_act_blank = '0;
   logic [3:0]  m_disp_dp = '0, m_disp_blank = '0;
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_e = 0; m_pend_full = 1'b0;
         m_act_data = '0; m_act_dp = '0; m_act_blank = '0;
         m_disp_data = '0; m_disp_dp = '0; m_disp_blank = '0;
      end else begin
         m_disp_data = m_act_data; m_disp_dp = m_act_dp; m_disp_blank = m_act_blank;
         m_e++;
         if (m_e % 16 == 0 && m_pend_full) begin
            m_act_data = m_pend_data; m_act_dp = m_pend_dp; m_act_blank = m_pend_blank;
            m_pend_full = 1'b0;
         end else if (load_valid && !m_pend_full) begin
            m_pend_data = data_in; m_pend_dp = dp_in; m_pend_blank = blank_in;
            m_pend_full = 1'b1;
         end
      end
   end
   function automatic logic [13:0] exp_out();
      int d;
      logic dark, ft;
      logic [3:0] an;
      if (m_e == 0) return {4'hF, 7'h00, 1'b0, 1'b0, 1'b1};
      d = ((m_e - 1) / 4) % 4;
      dark = m_disp_blank[d];
`ifdef DISPLAY_LZB_EN
      if (d != 0 && !m_disp_dp[d] && (m_disp_data >> (4 * d)) == 16'h0) dark = 1'b1;
`endif
      an = 4'hF;
      if (!dark) an[d] = 1'b0;
      ft = m_e > 1 && (m_e - 1) % 16 == 0;
      return {an, dark ? 7'h00 : seg_tab[(m_disp_data >> (4 * d)) & 16'hF],
              !dark && m_disp_dp[d], ft, !m_pend_full};
   endfunction
   logic [13:0] obs;
   assign obs = {anodo, catodo, dp_out, frame_tick, load_ready};
   task automatic test_reset();
      data_in = 16'h1A3F; dp_in = '0; blank_in = '0; load_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         n_chk++;
         if (obs !== 14'b1111_0000000_0_0_1) $display("FAIL reset_state got=%b exp=%b", obs, 14'b1111_0000000_0_0_1);
         else n_pass++;
      end
      reset = 1'b1;
   endtask
   task automatic test_first_load();
      logic [6:0] want [4] = '{7'b1000111, 7'b1111001, 7'b1110111, 7'b0110000};
      repeat (40) begin
         @(negedge clk);
         load_valid = 1'b0;
         n_chk++;
         if (obs !== exp_out()) $display("FAIL first_load e=%0d got=%b exp=%b", m_e, obs, exp_out());
         else n_pass++;
         if (m_e >= 1 && m_e <= 16) begin
            n_chk++;
            if (catodo !== 7'b1111110) $display("FAIL pre_commit e=%0d got=%b exp=%b", m_e, catodo, 7'b1111110);
            else n_pass++;
         end else if (m_e >= 17 && m_e <= 32 && (m_e - 17) % 4 == 0) begin
            n_chk++;
            if (catodo !== want[(m_e - 17) / 4]) $display("FAIL first_frame e=%0d got=%b exp=%b", m_e, catodo, want[(m_e - 17) / 4]);
            else n_pass++;
         end
      end
   endtask
   task automatic test_handshake();
      while (m_e % 16 != 5) @(negedge clk);
      data_in = 16'($urandom); dp_in = 4'($urandom); blank_in = '0; load_valid = 1'b1;
      @(negedge clk);
      data_in = 16'($urandom); dp_in = 4'($urandom);
      repeat (3) begin
         n_chk++;
         if (load_ready !== 1'b0) $display("FAIL ready_drop e=%0d got=%b exp=0", m_e, load_ready);
         else n_pass++;
         @(negedge clk);
      end
      load_valid = 1'b0;
      repeat (30) begin
         n_chk++;
         if (obs !== exp_out()) $display("FAIL handshake e=%0d got=%b exp=%b", m_e, obs, exp_out());
         else n_pass++;
         @(negedge clk);
      end
   endtask
   task automatic test_blank_dp();
      data_in = 16'($urandom); dp_in = 4'b0001; blank_in = 4'b0100; load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      repeat (40) begin
         @(negedge clk);
         n_chk++;
         if (obs !== exp_out()) $display("FAIL blank_dp e=%0d got=%b exp=%b", m_e, obs, exp_out());
         else n_pass++;
      end
   endtask
   task automatic test_lzb(input logic [15:0] val);
      data_in = val; dp_in = '0; blank_in = '0; load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      repeat (36) begin
         @(negedge clk);
         n_chk++;
         if (obs !== exp_out()) $display("FAIL lzb_%h e=%0d got=%b exp=%b", val, m_e, obs, exp_out());
         else n_pass++;
      end
   endtask
   task automatic test_back_to_back();
      while (m_e % 16 != 15 || !load_ready) @(negedge clk);
      load_valid = 1'b1;
      repeat (60) begin
         data_in = 16'($urandom); dp_in = 4'($urandom); blank_in = 4'($urandom);
         @(negedge clk);
         n_chk++;
         if (obs !== exp_out()) $display("FAIL back_to_back e=%0d got=%b exp=%b", m_e, obs, exp_out());
         else n_pass++;
      end
      load_valid = 1'b0;
   endtask
   task automatic test_random();
      repeat (200) begin
         load_valid = ($urandom_range(7) == 0);
         data_in = 16'($urandom); dp_in = 4'($urandom); blank_in = 4'($urandom);
         @(negedge clk);
         n_chk++;
         if (obs !== exp_out()) $display("FAIL random e=%0d got=%b exp=%b", m_e, obs, exp_out());
         else n_pass++;
      end
      load_valid = 1'b0;
   endtask
   task automatic test_async_reset();
      while (m_e % 16 != 3 || !load_ready) @(negedge clk);
      data_in = 16'($urandom) | 16'h1111; dp_in = 4'hF; load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      n_chk++;
      if (load_ready !== 1'b0) $display("FAIL pend_full got=%b exp=0", load_ready);
      else n_pass++;
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      n_chk++;
      if (obs !== 14'b1111_0000000_0_0_1) $display("FAIL async_reset got=%b exp=%b", obs, 14'b1111_0000000_0_0_1);
      else n_pass++;
      @(negedge clk);
      reset = 1'b1;
      repeat (20) begin
         @(negedge clk);
         n_chk++;
         if (obs !== exp_out() || catodo === 7'b0) $display("FAIL post_reset e=%0d got=%b exp=%b", m_e, obs, exp_out());
         else n_pass++;
      end
   endtask
   initial begin
      test_reset();
      test_first_load();
      test_handshake();
      test_blank_dp();
      test_lzb(16'h0050);
      test_lzb(16'h0000);
      test_back_to_back();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
